// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and sequencer sharing one single-port SRAM among NREQ requesters.
// Latency: req_ready is combinational in IDLE; rsp_valid follows 2 cycles after grant, +1 per SRAM FREE/BUSY cycle (3 cycles/txn min).
// Backpressure: one transaction in flight; requesters hold until req_ready, the SRAM stalls via sram_state. Optional watchdog: SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
    parameter int NREQ           = 4,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic                     sram_read_en,
    output logic                     sram_write_en,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_write_data,
    input  logic [DATA_W-1:0]        sram_read_data,
    input  logic [1:0]               sram_state,
    output logic                     timeout_err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] SRAM_ACCESS = 2'd2;
    localparam logic [1:0] SRAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                any_vld;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    cand;

    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];

    // Split the packed request buses into per-requester slices
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`else
    // Watchdog compiled out: the limit has no effect in this build
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    // Round-robin scan: first valid requester after the last winner, wrapping
    always_comb begin
        any_vld = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                winner  = cand;
            end
        end
    end

    // State register and transaction latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_W'(NREQ - 1);
            owner_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`endif

    // Next-state logic: grant in IDLE, wait on the SRAM in ACCESS, one RESP cycle
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef SRAM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    wr_d     = req_write[winner];
                    addr_d   = addr_arr[winner];
                    wdata_d  = wdata_arr[winner];
                    owner_d  = winner;
                    rr_ptr_d = winner;
                    state_d  = ACCESS;
`ifdef SRAM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ACCESS: begin
                if (sram_state == SRAM_ACCESS) begin
                    // Completion wins over the watchdog when both land together
                    rdata_d = wr_q ? '0 : sram_read_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (sram_state == SRAM_ERROR) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
`ifdef SRAM_ARB_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: grant pulse in IDLE, SRAM drive in ACCESS, completion in RESP
    always_comb begin
        req_ready       = '0;
        rsp_valid       = '0;
        rsp_err         = 1'b0;
        rsp_rdata       = '0;
        busy            = 1'b0;
        sram_read_en    = 1'b0;
        sram_write_en   = 1'b0;
        sram_addr       = '0;
        sram_write_data = '0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    req_ready[winner] = 1'b1;
                end
            end
            ACCESS: begin
                busy            = 1'b1;
                sram_read_en    = !wr_q;
                sram_write_en   = wr_q;
                sram_addr       = addr_q;
                sram_write_data = wr_q ? wdata_q : '0;
            end
            RESP: begin
                busy               = 1'b1;
                rsp_valid[owner_q] = 1'b1;
                rsp_err            = err_q;
                rsp_rdata          = rdata_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic               rsp_err, busy, sram_read_en, sram_write_en, timeout_err;
    logic [DW-1:0]      rsp_rdata, sram_write_data, sram_read_data;
    logic [AW-1:0]      sram_addr;
    logic [1:0]         sram_state;

    always #5 clk = ~clk;

    sram_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .busy(busy), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_addr(sram_addr), .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
        .sram_state(sram_state), .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: requester intents, round-robin pointer, memory image
    int            m_rr;
    logic          exp_tmo;
    logic          pend   [NREQ];
    logic          pwr    [NREQ];
    logic [AW-1:0] paddr  [NREQ];
    logic [DW-1:0] pwdata [NREQ];
    logic [DW-1:0] ref_mem  [1024];
    logic [DW-1:0] sram_mem [1024];
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = pwr[i];
            req_addr[i*AW +: AW]    = paddr[i];
            req_wdata[i*DW +: DW]   = pwdata[i];
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1; pwr[i] = wr; paddr[i] = a; pwdata[i] = d;
    endtask

    // One arbitration round. nbusy FREE/BUSY cycles, then fin: 2 done, 3 error, -1 none (watchdog)
    task automatic do_txn(input int nbusy, input int fin);
        int            w;
        int            idx;
        int            ncyc;
        logic          e_err;
        logic [DW-1:0] e_rd;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (w < 0 && pend[idx]) w = idx;
        end
        drive_reqs();
        sram_state = 2'd0;
        sram_read_data = $urandom;
        @(negedge clk);
        last_ready = req_ready;
        chk("idle_ready", req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
        chk("idle_busy", busy, 0);
        chk("idle_en", {sram_read_en, sram_write_en}, 0);
        chk("idle_rspv", rsp_valid, 0);
        chk("idle_tmo", timeout_err, exp_tmo);
        @(posedge clk); #1;
        if (w < 0) return;
        m_rr = w;
        pend[w] = 1'b0;
        drive_reqs();
        ncyc = (fin < 0) ? nbusy : nbusy + 1;
        for (int c = 0; c < ncyc; c++) begin
            if (c < nbusy) begin
                sram_state = 2'($urandom_range(0, 1));
                sram_read_data = $urandom;
            end else begin
                sram_state = 2'(fin);
                sram_read_data = sram_mem[sram_addr];
            end
            @(negedge clk);
            chk("acc_rd_en", sram_read_en, !pwr[w]);
            chk("acc_wr_en", sram_write_en, pwr[w]);
            chk("acc_addr", sram_addr, paddr[w]);
            chk("acc_wdata", sram_write_data, pwr[w] ? pwdata[w] : 32'd0);
            chk("acc_busy", busy, 1);
            chk("acc_rspv", rsp_valid, 0);
            chk("acc_ready", req_ready, 0);
            if (c == nbusy && fin == 2 && sram_write_en === 1'b1)
                sram_mem[sram_addr] = sram_write_data;
            @(posedge clk); #1;
        end
        sram_state = 2'd0;
        sram_read_data = $urandom;
        e_err = (fin != 2);
        e_rd  = (fin == 2 && !pwr[w]) ? ref_mem[paddr[w]] : 32'd0;
        if (fin == 2 && pwr[w]) ref_mem[paddr[w]] = pwdata[w];
        if (fin < 0) exp_tmo = 1'b1;
        @(negedge clk);
        chk("resp_valid", rsp_valid, 64'd1 << w);
        chk("resp_err", rsp_err, e_err);
        chk("resp_rdata", rsp_rdata, e_rd);
        chk("resp_busy", busy, 1);
        chk("resp_en", {sram_read_en, sram_write_en}, 0);
        chk("resp_tmo", timeout_err, exp_tmo);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        sram_state = 2'd0; sram_read_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end
        for (int a = 0; a < 1024; a++) begin
            ref_mem[a] = '0; sram_mem[a] = '0;
        end
        m_rr = NREQ - 1;
        exp_tmo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", {sram_read_en, sram_write_en}, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_write_data, 0);
        chk("rst_tmo", timeout_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write from requester 1, SRAM ready immediately
        set_req(1, 1'b1, 10'h005, 32'hDEADBEEF);
        do_txn(0, 2);
        chk("wr_grant", last_ready, 4'b0010);

        // Read-back from requester 3 after three stall cycles
        set_req(3, 1'b0, 10'h005, 32'h0);
        do_txn(3, 2);
        chk("rd_grant", last_ready, 4'b1000);

        // All requesters pending continuously: strict rotation from index 0
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i]) set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            do_txn(0, 2);
            chk("rr_order", last_ready, 64'd1 << order[j]);
        end

        // SRAM error on a read from requester 2, then a normal write from requester 0
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        set_req(2, 1'b0, 10'h005, 32'h0);
        do_txn(0, 3);
        set_req(0, 1'b1, 10'h00A, 32'hCAFEF00D);
        do_txn(1, 2);
        chk("after_err_grant", last_ready, 4'b0001);

        // Reset in the second ACCESS cycle abandons the write silently
        set_req(1, 1'b1, 10'h007, 32'h12345678);
        drive_reqs();
        sram_state = 2'd0;
        @(negedge clk);
        chk("mid_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        pend[1] = 1'b0; drive_reqs(); sram_state = 2'd1;
        @(negedge clk);
        chk("mid_acc1_we", sram_write_en, 1);
        @(posedge clk); #1;
        rst = 1'b1; sram_state = 2'd1;
        @(negedge clk);
        chk("mid_acc2_we", sram_write_en, 1);
        @(posedge clk); #1;
        rst = 1'b0; sram_state = 2'd0;
        m_rr = NREQ - 1; exp_tmo = 1'b0;
        @(negedge clk);
        chk("mid_after_en", {sram_read_en, sram_write_en}, 0);
        chk("mid_after_rspv", rsp_valid, 0);
        chk("mid_after_busy", busy, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 10'h007, 32'h0);
        set_req(1, 1'b0, 10'h005, 32'h0);
        set_req(2, 1'b1, 10'h003, 32'h0BADC0DE);
        do_txn(0, 2);
        chk("mid_rr_ptr", last_ready, 4'b0001);

`ifdef SRAM_ARB_TIMEOUT_EN
        // SRAM stuck: watchdog aborts after the limit, flag stays set afterwards
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        set_req(2, 1'b0, 10'h005, 32'h0);
        do_txn(4, -1);
        set_req(3, 1'b1, 10'h009, 32'h55AA55AA);
        do_txn(0, 2);
        chk("tmo_sticky", timeout_err, 1);
`else
        // Without the watchdog a long stall still completes normally
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        set_req(2, 1'b0, 10'h005, 32'h0);
        do_txn(10, 2);
`endif

        // Randomized traffic against the reference model
        for (int t = 0; t < 250; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            do_txn($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 3 : 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
